// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_pkg;

    typedef enum logic {
        RF_INIT,
        RF_RUN
    } rf_state_e;

    localparam int unsigned DEFAULT_DATA_WIDTH    = 32;
    localparam int unsigned DEFAULT_ADDRESS_WIDTH = 5;
    localparam int unsigned DEFAULT_NUM_READ      = 2;
    localparam int unsigned DEFAULT_NUM_WRITE     = 2;

    // Number of entries addressed by an address of width aw.
    function automatic int unsigned depth_of(input int unsigned aw);
        return 32'(1) << aw;
    endfunction

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Clear-sweep controller: after reset or a clear request, walks every entry
// once, issuing a zero write per edge, then raises ready.
module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_req,
    output logic                     ready,
    output logic                     clr_we_c,
    output logic [ADDRESS_WIDTH-1:0] clr_addr
);

    rf_state_e                state;
    logic [ADDRESS_WIDTH-1:0] cnt;

    // Sweep FSM: INIT counts through every address, RUN waits for a clear request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RF_INIT;
            cnt   <= '0;
            ready <= 1'b0;
        end else if (state == RF_INIT) begin
            cnt <= cnt + ADDRESS_WIDTH'(1);
            if (&cnt) begin
                state <= RF_RUN;
                ready <= 1'b1;
            end
        end else if (clear_req) begin
            state <= RF_INIT;
            cnt   <= '0;
            ready <= 1'b0;
        end
    end

    assign clr_we_c = (state == RF_INIT);
    assign clr_addr = cnt;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with hardwired-zero x0, highest-index-wins write
// merge and a hardware clear sweep.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data
// to matching read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int unsigned NUM_READ      = DEFAULT_NUM_READ,
    parameter int unsigned NUM_WRITE     = DEFAULT_NUM_WRITE
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_READ*ADDRESS_WIDTH-1:0] ReadAddr,
    output logic [NUM_READ*DATA_WIDTH-1:0]    ReadData,
    input  logic [NUM_WRITE-1:0]              WriteEnable,
    input  logic [NUM_WRITE*ADDRESS_WIDTH-1:0] WriteAddr,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0]   WriteData,
    input  logic                              ClearReq,
    output logic                              Ready
);

    localparam int unsigned DEPTH = depth_of(ADDRESS_WIDTH);

    logic [DATA_WIDTH-1:0]    mem [DEPTH];
    logic                     clr_we_c;
    logic [ADDRESS_WIDTH-1:0] clr_addr;

    regfile_clear_ctrl #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_clear_ctrl (
        .clk      (clk),
        .rst      (rst),
        .clear_req(ClearReq),
        .ready    (Ready),
        .clr_we_c (clr_we_c),
        .clr_addr (clr_addr)
    );

    // Storage update: sweep zeroes during init; in run, ports are applied in
    // ascending order so the highest-index port wins an address conflict.
    always_ff @(posedge clk) begin
        if (clr_we_c) begin
            mem[clr_addr] <= '0;
        end else if (!ClearReq) begin
            for (int unsigned w = 0; w < NUM_WRITE; w++) begin
                if (WriteEnable[w] && (WriteAddr[w*ADDRESS_WIDTH +: ADDRESS_WIDTH] != '0)) begin
                    mem[WriteAddr[w*ADDRESS_WIDTH +: ADDRESS_WIDTH]] <= WriteData[w*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Combinational read muxes; x0 and the init state always read zero.
    always_comb begin
        ReadData = '0;
        for (int unsigned r = 0; r < NUM_READ; r++) begin
            if (Ready && (ReadAddr[r*ADDRESS_WIDTH +: ADDRESS_WIDTH] != '0)) begin
                ReadData[r*DATA_WIDTH +: DATA_WIDTH] = mem[ReadAddr[r*ADDRESS_WIDTH +: ADDRESS_WIDTH]];
`ifdef REGFILE_BYPASS_EN
                for (int unsigned w = 0; w < NUM_WRITE; w++) begin
                    if (WriteEnable[w] &&
                        (WriteAddr[w*ADDRESS_WIDTH +: ADDRESS_WIDTH] == ReadAddr[r*ADDRESS_WIDTH +: ADDRESS_WIDTH])) begin
                        ReadData[r*DATA_WIDTH +: DATA_WIDTH] = WriteData[w*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
`endif
            end
        end
    end

endmodule
